// File: rtl/gb_serial.sv
// ============================================================================
// gb_serial : Game Boy link-port controller (SB/SC registers, 8-bit shifter)
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module gb_serial #(
  parameter int BIT_PERIOD  = 512,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  data_i,
  input  logic [15:0] addr,
  input  logic        wren,
  output logic [7:0]  data_o,
  output logic        irq_serial,
  output logic        sclk_o,
  output logic        sclk_oe,
  input  logic        sclk_i,
  output logic        sout,
  input  logic        sin
);

  localparam int                 c_HALF     = BIT_PERIOD / 2;
  localparam int                 c_DIV_W    = (c_HALF > 1) ? $clog2(c_HALF) : 1;
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(c_HALF - 1);
  localparam logic [15:0]        c_ADDR_SB  = 16'hFF01;
  localparam logic [15:0]        c_ADDR_SC  = 16'hFF02;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2
  } state_t;

  state_t               r_state;
  logic [7:0]           r_sb;
  logic                 r_sc7;
  logic                 r_sc0;
  logic [3:0]           r_bit_cnt;
  logic [c_DIV_W-1:0]   r_div;
  logic                 r_sout;
  logic                 r_sclk_o;
  logic                 r_irq;
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_sin_sync;
  logic                 r_sclk_prev;

  logic w_wr_sb;
  logic w_wr_sc;
  logic w_sclk_s;
  logic w_sin_s;
  logic w_div_last;
  logic w_shift;
  logic w_unshift;
  logic [7:0] w_rdata;

  assign w_wr_sb    = wren && (addr == c_ADDR_SB);
  assign w_wr_sc    = wren && (addr == c_ADDR_SC);
  assign w_sclk_s   = r_sclk_sync[SYNC_STAGES-1];
  assign w_sin_s    = r_sin_sync[SYNC_STAGES-1];
  assign w_div_last = (r_div == c_DIV_LAST);

  // Shift on the rising serial edge, present next bit on the falling edge;
  // the edge source is the divider (internal) or the synchronized sclk_i.
  assign w_shift   = r_sc0 ? (r_state == S_LOW  && w_div_last)
                           : (r_state != S_IDLE && w_sclk_s && !r_sclk_prev);
  assign w_unshift = r_sc0 ? (r_state == S_HIGH && w_div_last)
                           : (r_state != S_IDLE && !w_sclk_s && r_sclk_prev);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sclk_sync <= '1;
      r_sin_sync  <= '1;
      r_sclk_prev <= 1'b1;
    end else begin
      r_sclk_sync[0] <= sclk_i;
      r_sin_sync[0]  <= sin;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sclk_sync[i] <= r_sclk_sync[i-1];
        r_sin_sync[i]  <= r_sin_sync[i-1];
      end
      r_sclk_prev <= w_sclk_s;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_sb      <= 8'h00;
      r_sc7     <= 1'b0;
      r_sc0     <= 1'b0;
      r_bit_cnt <= 4'd0;
      r_div     <= '0;
      r_sout    <= 1'b1;
      r_sclk_o  <= 1'b1;
      r_irq     <= 1'b0;
    end else begin
      r_irq <= 1'b0;
      // An SC write overrides any in-flight edge, including completion.
      if (w_wr_sc) begin
        r_sc0     <= data_i[0];
        r_bit_cnt <= 4'd0;
        r_div     <= '0;
        if (data_i[7]) begin
          r_sc7    <= 1'b1;
          r_state  <= S_LOW;
          r_sclk_o <= ~data_i[0];
          r_sout   <= r_sb[7];
        end else begin
          r_sc7    <= 1'b0;
          r_state  <= S_IDLE;
          r_sclk_o <= 1'b1;
          r_sout   <= 1'b1;
        end
      end else if (r_state != S_IDLE) begin
        if (r_sc0) begin
          r_div <= w_div_last ? '0 : r_div + 1'b1;
        end
        if (w_shift) begin
          r_sb      <= {r_sb[6:0], w_sin_s};
          r_bit_cnt <= r_bit_cnt + 1'b1;
          r_sclk_o  <= 1'b1;
          if (r_bit_cnt == 4'd7) begin
            r_state <= S_IDLE;
            r_sc7   <= 1'b0;
            r_sout  <= 1'b1;
            r_irq   <= 1'b1;
          end else begin
            r_state <= S_HIGH;
          end
        end else if (w_unshift) begin
          r_state  <= S_LOW;
          r_sout   <= r_sb[7];
          r_sclk_o <= ~r_sc0;
        end
      end else if (w_wr_sb) begin
        r_sb <= data_i;
      end
    end
  end

  always_comb begin
    w_rdata = 8'hFF;
    case (addr)
      c_ADDR_SB: w_rdata = r_sb;
      c_ADDR_SC: w_rdata = {r_sc7, 6'b111111, r_sc0};
      default:   w_rdata = 8'hFF;
    endcase
  end

  assign data_o     = w_rdata;
  assign irq_serial = r_irq;
  assign sclk_o     = r_sclk_o;
  assign sclk_oe    = r_sc0;
  assign sout       = r_sout;

endmodule

`default_nettype wire

// File: tb/tb_gb_serial.sv
// ============================================================================
// tb_gb_serial : randomized self-checking bench for the gb_serial link port
// Revision     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gb_serial;

  localparam int c_BP       = 8;
  localparam int c_IRQ_LAT  = c_BP / 2 + 7 * c_BP;
  localparam logic [15:0] c_SB = 16'hFF01;
  localparam logic [15:0] c_SC = 16'hFF02;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  data_i;
  logic [15:0] addr;
  logic        wren;
  logic [7:0]  data_o;
  logic        irq_serial;
  logic        sclk_o;
  logic        sclk_oe;
  logic        sclk_i;
  logic        sout;
  logic        sin_drv;
  logic        loop_en;
  logic        sin_w;

  int errors = 0;
  int checks = 0;

  assign sin_w = loop_en ? sout : sin_drv;

  gb_serial #(.BIT_PERIOD(c_BP), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .data_i(data_i), .addr(addr), .wren(wren),
    .data_o(data_o), .irq_serial(irq_serial), .sclk_o(sclk_o),
    .sclk_oe(sclk_oe), .sclk_i(sclk_i), .sout(sout), .sin(sin_w)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; data_i = d; wren = 1'b1;
    @(negedge clk);
    wren = 1'b0; addr = 16'h0000; data_i = 8'h00;
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] d);
    addr = a;
    #1;
    d = data_o;
    addr = 16'h0000;
  endtask

  // Runs one internal-clock exchange: the partner presents its byte MSB-first,
  // changing bit after each sclk_o rise. Returns what was observed.
  task automatic run_xfer(input logic [7:0] sb, input logic [7:0] partner,
                          output int irq_k, output int irq_n,
                          output logic [7:0] sout_bits,
                          output int low_n, output int low_ph);
    logic prev;
    int   nb;
    cpu_write(c_SB, sb);
    sin_drv = partner[7];
    nb = 1;
    cpu_write(c_SC, 8'h81);
    prev = 1'b1; irq_k = -1; irq_n = 0; sout_bits = 8'h00; low_n = 0; low_ph = 0;
    for (int k = 0; k < 80; k++) begin
      if (irq_serial) begin
        irq_n++;
        if (irq_k < 0) irq_k = k;
      end
      if (irq_k < 0) begin
        if (!sclk_o) low_n++;
        if (prev && !sclk_o) begin
          if (low_ph < 8) sout_bits[7-low_ph] = sout;
          low_ph++;
        end
        if (!prev && sclk_o && nb < 8) begin
          sin_drv = partner[7-nb];
          nb++;
        end
      end
      prev = sclk_o;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    logic [7:0] d;
    loop_en = 1'b0; sin_drv = 1'b1;
    cpu_write(c_SB, 8'hA5);
    cpu_write(c_SC, 8'h81);
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (sout !== 1'b1) begin errors++; $display("FAIL reset_sout: got %b required 1", sout); end
    checks++; if (sclk_o !== 1'b1) begin errors++; $display("FAIL reset_sclk: got %b required 1", sclk_o); end
    checks++; if (irq_serial !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b required 0", irq_serial); end
    @(negedge clk);
    reset = 1'b0;
    rd(c_SC, d);
    checks++; if (d !== 8'h7E) begin errors++; $display("FAIL reset_sc: got %h required 7e", d); end
    rd(c_SB, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_sb: got %h required 00", d); end
    rd(16'hFF00, d);
    checks++; if (d !== 8'hFF) begin errors++; $display("FAIL unmapped_read: got %h required ff", d); end
  endtask

  task automatic test_loopback;
    int irq_k, irq_n, low_n, low_ph;
    logic [7:0] bits, d;
    loop_en = 1'b1;
    run_xfer(8'h48, 8'h00, irq_k, irq_n, bits, low_n, low_ph);
    checks++; if (irq_k !== c_IRQ_LAT) begin errors++; $display("FAIL loop_irq_time: got %0d required %0d", irq_k, c_IRQ_LAT); end
    checks++; if (irq_n !== 1) begin errors++; $display("FAIL loop_irq_count: got %0d required 1", irq_n); end
    checks++; if (bits !== 8'h48) begin errors++; $display("FAIL loop_sout_seq: got %h required 48", bits); end
    checks++; if (low_ph !== 8 || low_n !== 8 * (c_BP / 2)) begin
      errors++; $display("FAIL loop_sclk_shape: got %0d phases %0d low cycles required 8 and %0d", low_ph, low_n, 8 * (c_BP / 2));
    end
    rd(c_SB, d);
    checks++; if (d !== 8'h48) begin errors++; $display("FAIL loop_sb: got %h required 48", d); end
    rd(c_SC, d);
    checks++; if (d !== 8'h7F) begin errors++; $display("FAIL loop_sc: got %h required 7f", d); end
    loop_en = 1'b0;
  endtask

  task automatic test_no_partner;
    int irq_k, irq_n, low_n, low_ph;
    logic [7:0] bits, d;
    run_xfer(8'hA5, 8'hFF, irq_k, irq_n, bits, low_n, low_ph);
    rd(c_SB, d);
    checks++; if (d !== 8'hFF) begin errors++; $display("FAIL nopartner_sb: got %h required ff", d); end
    checks++; if (irq_n !== 1) begin errors++; $display("FAIL nopartner_irq: got %0d required 1", irq_n); end
    checks++; if (bits !== 8'hA5) begin errors++; $display("FAIL nopartner_sout: got %h required a5", bits); end
  endtask

  task automatic test_random_exchange;
    int irq_k, irq_n, low_n, low_ph;
    logic [7:0] bits, d, sb, pt;
    for (int n = 0; n < 4; n++) begin
      sb = 8'($urandom); pt = 8'($urandom);
      run_xfer(sb, pt, irq_k, irq_n, bits, low_n, low_ph);
      rd(c_SB, d);
      checks++; if (d !== pt) begin errors++; $display("FAIL rand_sb[%0d]: got %h required %h", n, d, pt); end
      checks++; if (bits !== sb) begin errors++; $display("FAIL rand_sout[%0d]: got %h required %h", n, bits, sb); end
      checks++; if (irq_k !== c_IRQ_LAT || irq_n !== 1) begin
        errors++; $display("FAIL rand_irq[%0d]: got time %0d count %0d required %0d and 1", n, irq_k, irq_n, c_IRQ_LAT);
      end
    end
  endtask

  task automatic test_external;
    logic [7:0] d, bits;
    int early, irq_n, irq_p;
    sin_drv = 1'b0; sclk_i = 1'b1;
    cpu_write(c_SB, 8'h0F);
    cpu_write(c_SC, 8'h80);
    checks++; if (sclk_oe !== 1'b0 || sclk_o !== 1'b1) begin
      errors++; $display("FAIL ext_sclk_out: got oe=%b sclk=%b required 0 and 1", sclk_oe, sclk_o);
    end
    early = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (irq_serial) early++;
    end
    rd(c_SC, d);
    checks++; if (d !== 8'hFE || early !== 0) begin
      errors++; $display("FAIL ext_wait: got sc=%h irqs=%0d required fe and 0", d, early);
    end
    irq_n = 0; irq_p = -1; bits = 8'h00;
    for (int p = 0; p < 8; p++) begin
      sclk_i = 1'b0;
      for (int j = 0; j < 6; j++) begin
        @(negedge clk);
        if (irq_serial) begin irq_n++; irq_p = p; end
      end
      bits[7-p] = sout;
      sclk_i = 1'b1;
      for (int j = 0; j < 6; j++) begin
        @(negedge clk);
        if (irq_serial) begin irq_n++; irq_p = p; end
      end
    end
    checks++; if (irq_n !== 1 || irq_p !== 7) begin
      errors++; $display("FAIL ext_irq: got count %0d at pulse %0d required 1 at 7", irq_n, irq_p);
    end
    checks++; if (bits !== 8'h0F) begin errors++; $display("FAIL ext_sout: got %h required 0f", bits); end
    rd(c_SB, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL ext_sb: got %h required 00", d); end
    rd(c_SC, d);
    checks++; if (d !== 8'h7E || sout !== 1'b1) begin
      errors++; $display("FAIL ext_done: got sc=%h sout=%b required 7e and 1", d, sout);
    end
  endtask

  task automatic test_abort_restart;
    logic [7:0] d, bits;
    int bad, irq_k, irq_n, low_n, low_ph;
    sin_drv = 1'b1;
    cpu_write(c_SC, 8'h81);
    repeat (24) @(negedge clk);
    cpu_write(c_SC, 8'h01);
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      if (irq_serial || !sclk_o || !sout) bad++;
      @(negedge clk);
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL abort_quiet: got %0d bad cycles required 0", bad); end
    rd(c_SC, d);
    checks++; if (d !== 8'h7F) begin errors++; $display("FAIL abort_sc: got %h required 7f", d); end
    rd(c_SB, d);
    checks++; if (d !== 8'h07) begin errors++; $display("FAIL abort_sb: got %h required 07", d); end
    run_xfer(8'h33, 8'h5A, irq_k, irq_n, bits, low_n, low_ph);
    checks++; if (bits !== 8'h33) begin errors++; $display("FAIL restart_sout: got %h required 33", bits); end
    rd(c_SB, d);
    checks++; if (d !== 8'h5A || irq_k !== c_IRQ_LAT || irq_n !== 1) begin
      errors++; $display("FAIL restart_xfer: got sb=%h irq at %0d x%0d required 5a at %0d x1", d, irq_k, irq_n, c_IRQ_LAT);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] d;
    int irq_k, irq_n;
    loop_en = 1'b1;
    cpu_write(c_SB, 8'h3C);
    cpu_write(c_SC, 8'h81);
    repeat (20) @(negedge clk);
    cpu_write(c_SB, 8'h55);
    repeat (36) @(negedge clk);
    cpu_write(c_SB, 8'h99);
    checks++; if (irq_serial !== 1'b1) begin errors++; $display("FAIL busy_irq: got %b required 1", irq_serial); end
    rd(c_SB, d);
    checks++; if (d !== 8'h3C) begin errors++; $display("FAIL busy_sb_write: got %h required 3c", d); end
    cpu_write(c_SC, 8'h81);
    repeat (58) @(negedge clk);
    cpu_write(c_SC, 8'h81);
    rd(c_SC, d);
    checks++; if (irq_serial !== 1'b0 || sclk_o !== 1'b0 || d !== 8'hFF) begin
      errors++; $display("FAIL collide: got irq=%b sclk=%b sc=%h required 0 0 ff", irq_serial, sclk_o, d);
    end
    irq_k = -1; irq_n = 0;
    for (int k = 0; k < 80; k++) begin
      if (irq_serial) begin irq_n++; if (irq_k < 0) irq_k = k; end
      @(negedge clk);
    end
    checks++; if (irq_k !== c_IRQ_LAT || irq_n !== 1) begin
      errors++; $display("FAIL collide_restart: got irq at %0d x%0d required %0d x1", irq_k, irq_n, c_IRQ_LAT);
    end
    loop_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wren = 1'b0; addr = 16'h0000; data_i = 8'h00;
    sclk_i = 1'b1; sin_drv = 1'b1; loop_en = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_loopback();
    test_no_partner();
    test_random_exchange();
    test_external();
    test_abort_restart();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
